detector_jogada: RTL and testbench

DETECTOR_JOGADA -- requirements
Module: detector_jogada

---
 rtl/jogada_pkg.sv | 13 +
 rtl/sincronizador.sv | 23 ++
 rtl/detector_jogada.sv | 129 ++++++++++++
 tb/tb_detector_jogada.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jogada_pkg.sv
// Shared constants for the move detector: FSM state encoding and default switch count.
package jogada_pkg;

    localparam int N_CHAVES_PADRAO = 4;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        FILTRA = 2'd1,
        PULSO  = 2'd2,
        SOLTA  = 2'd3
    } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a vector of asynchronous inputs, synchronous active-high reset.
module sincronizador #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    output logic [LARGURA-1:0] saida
);

    logic [LARGURA-1:0] estagio1;

    always_ff @(posedge clock) begin
        if (reset) begin
            estagio1 <= '0;
            saida    <= '0;
        end else begin
            estagio1 <= entrada;
            saida    <= estagio1;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Debounced player-move detector: emits one fez_jogada pulse per accepted switch pattern.
// Optional debounce filter enabled by defining DETECTOR_JOGADA_DEBOUNCE_EN.
//
// state  | meaning
// ESPERA | idle, waiting for a nonzero pattern while habilita is high
// FILTRA | candidate pattern must stay stable for DEBOUNCE_CICLOS cycles
// PULSO  | one-cycle fez_jogada, jogada/multipla just loaded
// SOLTA  | waiting for switches released (zero) before re-arming
module detector_jogada
    import jogada_pkg::*;
#(
    parameter int N_CHAVES        = N_CHAVES_PADRAO,
    parameter int DEBOUNCE_CICLOS = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_CHAVES-1:0] chaves,
    output logic                fez_jogada,
    output logic [N_CHAVES-1:0] jogada,
    output logic                multipla,
    output logic [1:0]          db_estado_det
);

    estado_t             estado, proximo;
    logic [N_CHAVES-1:0] sinc;

    sincronizador #(.LARGURA(N_CHAVES)) u_sinc (
        .clock   (clock),
        .reset   (reset),
        .entrada (chaves),
        .saida   (sinc)
    );

`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
    localparam int              CNT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [CNT_W-1:0]    contador, contador_prox;
    logic [N_CHAVES-1:0] candidato, candidato_prox;

    always_ff @(posedge clock) begin
        if (reset) begin
            contador  <= '0;
            candidato <= '0;
        end else begin
            contador  <= contador_prox;
            candidato <= candidato_prox;
        end
    end

    always_comb begin
        proximo        = estado;
        contador_prox  = contador;
        candidato_prox = candidato;
        case (estado)
            ESPERA: begin
                if (habilita && sinc != '0) begin
                    candidato_prox = sinc;
                    contador_prox  = '0;
                    proximo        = FILTRA;
                end
            end
            FILTRA: begin
                if (!habilita || sinc == '0) begin
                    contador_prox = '0;
                    proximo       = ESPERA;
                end else if (sinc != candidato) begin
                    candidato_prox = sinc;
                    contador_prox  = '0;
                end else if (contador == CNT_MAX) begin
                    contador_prox = '0;
                    proximo       = PULSO;
                end else begin
                    contador_prox = contador + 1'b1;
                end
            end
            PULSO: begin
                contador_prox = '0;
                proximo       = SOLTA;
            end
            SOLTA: begin
                // any nonzero sample restarts the release window
                if (sinc != '0) begin
                    contador_prox = '0;
                end else if (contador == CNT_MAX) begin
                    contador_prox = '0;
                    proximo       = ESPERA;
                end else begin
                    contador_prox = contador + 1'b1;
                end
            end
            default: proximo = ESPERA;
        endcase
    end
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CICLOS;

    always_comb begin
        proximo = estado;
        case (estado)
            ESPERA:  if (habilita && sinc != '0) proximo = PULSO;
            PULSO:   proximo = SOLTA;
            SOLTA:   if (sinc == '0) proximo = ESPERA;
            default: proximo = ESPERA;
        endcase
    end
`endif

    // On the edge into PULSO sinc equals the accepted pattern in both builds
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= ESPERA;
            jogada   <= '0;
            multipla <= 1'b0;
        end else begin
            estado <= proximo;
            if (proximo == PULSO && estado != PULSO) begin
                jogada   <= sinc;
                multipla <= ($countones(sinc) > 1);
            end
        end
    end

    assign fez_jogada    = (estado == PULSO);
    assign db_estado_det = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: directed scenarios plus random switch activity
// compared cycle by cycle against a run-length reference model.
module tb_detector_jogada;

    localparam int D = 4;
    localparam int N = 4;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
    localparam int NEED_RUN  = D + 1;
    localparam int NEED_ZERO = D;
    localparam int LAT       = 3 + D;
`else
    localparam int NEED_RUN  = 1;
    localparam int NEED_ZERO = 1;
    localparam int LAT       = 3;
`endif

    localparam int P_SEEK  = 0;
    localparam int P_PULSE = 1;
    localparam int P_REL   = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         habilita = 1'b0;
    logic [N-1:0] chaves = '0;
    logic         fez_jogada;
    logic [N-1:0] jogada;
    logic         multipla;
    logic [1:0]   db_estado_det;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int seen_filtra = 0;

    logic [N-1:0] m_c1 = '0, m_c2 = '0, m_run_val = '0, m_jog = '0;
    int           m_run_len = 0, m_zero_len = 0, m_phase = P_SEEK;

    detector_jogada #(.N_CHAVES(N), .DEBOUNCE_CICLOS(D)) dut (
        .clock         (clock),
        .reset         (reset),
        .habilita      (habilita),
        .chaves        (chaves),
        .fez_jogada    (fez_jogada),
        .jogada        (jogada),
        .multipla      (multipla),
        .db_estado_det (db_estado_det)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // A move is accepted after NEED_RUN consecutive enabled samples of the same nonzero
    // pattern; re-arming needs NEED_ZERO consecutive zero samples after the pulse cycle.
    task automatic model_edge(input logic h, input logic [N-1:0] ch, input logic r);
        logic [N-1:0] sv;
        if (r) begin
            m_c1 = '0; m_c2 = '0; m_run_val = '0; m_jog = '0;
            m_run_len = 0; m_zero_len = 0; m_phase = P_SEEK;
            return;
        end
        sv   = m_c2;
        m_c2 = m_c1;
        m_c1 = ch;
        case (m_phase)
            P_SEEK: begin
                if (h && sv != '0) begin
                    if (m_run_len > 0 && sv == m_run_val) m_run_len++;
                    else begin m_run_val = sv; m_run_len = 1; end
                end else m_run_len = 0;
                if (m_run_len == NEED_RUN) begin
                    m_phase = P_PULSE; m_jog = m_run_val; m_run_len = 0;
                end
            end
            P_PULSE: begin m_phase = P_REL; m_zero_len = 0; end
            default: begin
                if (sv == '0) m_zero_len++; else m_zero_len = 0;
                if (m_zero_len == NEED_ZERO) begin m_phase = P_SEEK; m_zero_len = 0; end
            end
        endcase
    endtask

    task automatic tick(input logic h, input logic [N-1:0] ch, input logic r);
        int exp_db;
        habilita = h; chaves = ch; reset = r;
        @(posedge clock);
        model_edge(h, ch, r);
        @(negedge clock);
        if (m_phase == P_PULSE)     exp_db = 2;
        else if (m_phase == P_REL)  exp_db = 3;
        else if (m_run_len > 0)     exp_db = 1;
        else                        exp_db = 0;
        chk("fez_jogada", int'(fez_jogada), int'(m_phase == P_PULSE));
        chk("jogada", int'(jogada), int'(m_jog));
        chk("multipla", int'(multipla), int'($countones(m_jog) > 1));
        chk("db_estado_det", int'(db_estado_det), exp_db);
        if (fez_jogada) pulses++;
        if (db_estado_det == 2'd1) seen_filtra++;
    endtask

    task automatic measure(input logic [N-1:0] ch, output int n);
        bit seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            tick(1'b1, ch, 1'b0);
            n++;
            if (fez_jogada) seen = 1;
        end
    endtask

    task automatic idle(input int cyc);
        for (int i = 0; i < cyc; i++) tick(1'b1, '0, 1'b0);
    endtask

    initial begin
        int n;
        logic [N-1:0] pat;
        logic h;
        int len;

        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        chk("reset_fez", int'(fez_jogada), 0);
        chk("reset_state", int'(db_estado_det), 0);
        idle(3);

        // stable press
        pulses = 0;
        measure(4'b0100, n);
        chk("latency_stable", n, LAT);
        chk("stable_jogada", int'(jogada), 4'b0100);
        chk("stable_multipla", int'(multipla), 0);
        for (int i = 0; i < 10; i++) tick(1'b1, 4'b0100, 1'b0);
        chk("stable_single_pulse", pulses, 1);
        idle(10);

        // bounce then hold
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'b0010, 1'b0); tick(1'b1, 4'b0010, 1'b0);
            tick(1'b1, 4'b0000, 1'b0); tick(1'b1, 4'b0000, 1'b0);
        end
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
        chk("bounce_no_pulse", pulses, 0);
`endif
        measure(4'b0010, n);
        chk("latency_bounce", n, LAT);
        chk("bounce_jogada", int'(jogada), 4'b0010);
        idle(10);

        // pattern change while filtering
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b0001, 1'b0);
        measure(4'b1000, n);
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
        chk("latency_change", n, LAT);
        chk("change_jogada", int'(jogada), 4'b1000);
`endif
        idle(10);

        // long hold, short release, proper release
        pulses = 0;
        for (int i = 0; i < 50; i++) tick(1'b1, 4'b0011, 1'b0);
        chk("hold_pulses", pulses, 1);
        chk("hold_multipla", int'(multipla), 1);
        pulses = 0;
        tick(1'b1, '0, 1'b0); tick(1'b1, '0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, 4'b0001, 1'b0);
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
        chk("short_release_no_pulse", pulses, 0);
`endif
        idle(8);
        pulses = 0;
        for (int i = 0; i < 20; i++) tick(1'b1, 4'b0001, 1'b0);
        chk("second_press_pulse", pulses, 1);
        chk("second_jogada", int'(jogada), 4'b0001);
        idle(10);

        // gating by habilita
        pulses = 0;
        for (int i = 0; i < 15; i++) tick(1'b0, 4'b0100, 1'b0);
        chk("gated_no_pulse", pulses, 0);
        chk("gated_state", int'(db_estado_det), 0);
        idle(10);

        // reset mid-filter
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b0100, 1'b1);
        chk("rst_fez", int'(fez_jogada), 0);
        chk("rst_jogada", int'(jogada), 0);
        chk("rst_multipla", int'(multipla), 0);
        chk("rst_state", int'(db_estado_det), 0);
        idle(6);

        // random activity
        for (int i = 0; i < 80; i++) begin
            pat = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            len = $urandom_range(1, 12);
            h   = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < len; k++) tick(h, pat, ($urandom_range(0, 150) == 0));
        end

`ifndef DETECTOR_JOGADA_DEBOUNCE_EN
        chk("no_filtra_state", seen_filtra, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
